// File: rtl/esm_buffer_ctrl.sv
// esm_buffer_ctrl: circular instruction-buffer controller for a simple in-order
// issue stage. It tracks occupancy, keeps the write/read pointers, and holds
// back the head entry for one cycle when it reads a register that the
// instruction issued just before it writes.
module esm_buffer_ctrl #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [Instruction_word_size-1:0] Instr_in,
  input  logic                             wr_en,
  input  logic                             RegWrite,
  input  logic                             ALUSrc,
  input  logic                             flush,
  input  logic                             issue_ready,
  output logic                             in_ready,
  output logic [$clog2(bs)-1:0]            buffer_index,
  output logic [$clog2(bs)-1:0]            issue_index,
  output logic                             issue_valid,
  output logic [0:bs-1]                    valid_entries,
  output logic [$clog2(bs):0]              count,
  output logic                             full,
  output logic                             empty
);

  localparam int AW = $clog2(bs);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW+1)'(1);
  localparam logic [AW:0]   CntFull = (AW+1)'(bs);

  // Control state: pointers, occupancy and the record of the last issue.
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [0:bs-1] r_valid;
  logic [AW:0]   r_count;
  logic          r_lastValid;
  logic [4:0]    r_lastRd;

  // Per-entry register-usage payload captured at write time.
  logic [4:0]    r_rd  [bs];
  logic [4:0]    r_rs1 [bs];
  logic [4:0]    r_rs2 [bs];
  logic [bs-1:0] r_rw;
  logic [bs-1:0] r_rs2Used;

  logic          w_full;
  logic          w_empty;
  logic          w_hazard;
  logic          w_issueValid;
  logic          w_wrFire;
  logic          w_issueFire;

  // Status, hazard detection and handshake decisions derived from the registers.
  always_comb begin
    w_full       = (r_count == CntFull);
    w_empty      = (r_count == '0);
    w_hazard     = r_lastValid &&
                   ((r_lastRd == r_rs1[r_rdPtr]) ||
                    (r_rs2Used[r_rdPtr] && (r_lastRd == r_rs2[r_rdPtr])));
    w_issueValid = !w_empty && !w_hazard;
    w_wrFire     = wr_en && !w_full && (|Instr_in) && !flush;
    w_issueFire  = w_issueValid && issue_ready && !flush;
  end

  // Drive the outputs straight from the registered state so reset forces them.
  always_comb begin
    in_ready      = !w_full;
    full          = w_full;
    empty         = w_empty;
    issue_valid   = w_issueValid;
    buffer_index  = r_wrPtr;
    issue_index   = r_rdPtr;
    valid_entries = r_valid;
    count         = r_count;
  end

  // Pointer, occupancy and last-issue bookkeeping; flush wipes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_valid     <= '0;
      r_count     <= '0;
      r_lastValid <= 1'b0;
      r_lastRd    <= '0;
    end else if (flush) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_valid     <= '0;
      r_count     <= '0;
      r_lastValid <= 1'b0;
      r_lastRd    <= '0;
    end else begin
      if (w_issueFire) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= r_rdPtr + PtrOne;
        r_lastValid      <= r_rw[r_rdPtr] && (r_rd[r_rdPtr] != 5'd0);
        r_lastRd         <= r_rd[r_rdPtr];
      end else begin
        r_lastValid      <= 1'b0;
      end
      if (w_wrFire) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + PtrOne;
      end
      case ({w_wrFire, w_issueFire})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the register fields of an accepted instruction into its slot.
  always_ff @(posedge clk) begin
    if (w_wrFire) begin
      r_rd[r_wrPtr]      <= Instr_in[11:7];
      r_rs1[r_wrPtr]     <= Instr_in[19:15];
      r_rs2[r_wrPtr]     <= Instr_in[24:20];
      r_rw[r_wrPtr]      <= RegWrite;
      r_rs2Used[r_wrPtr] <= !ALUSrc;
    end
  end

endmodule
